// File: rtl/spike_rec_pkg.sv
// Shared word format, mode and serialiser definitions for the multi-channel spike recorder.
package spike_rec_pkg;

  localparam int CW       = 4;
  localparam int EVT_FLAG = 15;
  localparam int CHAN_LSB = 11;
  localparam int TS_MSB   = 10;
  localparam logic [15:0] MARKER = 16'h0000;

  typedef enum logic {
    MODE_EVENT = 1'b0,
    MODE_COUNT = 1'b1
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } ser_state_e;

  function automatic logic [15:0] pack_word(input logic evt, input logic [CW-1:0] chan,
                                            input logic [TS_MSB:0] field);
    logic [15:0] w;
    w = '0;
    w[EVT_FLAG] = evt;
    w[CHAN_LSB +: CW] = chan;
    w[TS_MSB:0] = field;
    return w;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO; a write at full is accepted only when a pop frees a slot.
module spike_fifo #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [15:0]           din,
  input  logic                  rd_en,
  output logic [15:0]           dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  wr_drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_wr, do_rd;

  assign full  = level_q[DEPTH_LOG2];
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = empty ? 16'h0000 : mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_drop  = wr_en && !do_wr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates dout and pointers restart on flush.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spike_raster_fifo.sv
// Multi-channel spike recorder: event (channel+timestamp) or count-per-bin words into a FWFT FIFO.
module spike_raster_fifo
  import spike_rec_pkg::*;
#(
  parameter int NCH        = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int TSW        = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [NCH-1:0]       spike,
  input  logic                 rd_en,
  output logic [15:0]          dout,
  output logic                 empty,
  output logic [DEPTH_LOG2:0]  level,
  output logic [15:0]          drop_cnt,
  output logic                 overrun
);

  mode_e          mode_q, mode_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic           marker_q, marker_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [TSW-1:0] ts_lat_q [NCH];
  logic [TSW-1:0] ts_lat_d [NCH];
  logic [TSW-1:0] cnt_q [NCH];
  logic [TSW-1:0] cnt_d [NCH];
  logic [TSW-1:0] shadow_q [NCH];
  logic [TSW-1:0] shadow_d [NCH];
  ser_state_e     ser_q, ser_d;
  logic [CW-1:0]  ser_idx_q, ser_idx_d;
  logic           overrun_q, overrun_d;
  logic [15:0]    drop_q, drop_d;

  logic           is_evt, tick_act, ser_busy, snap;
  logic           grant_vld, grant_evt, ser_adv;
  logic [CW-1:0]  grant_idx;
  logic [4:0]     lost;
  logic           fifo_wr, fifo_drop, fifo_full;
  logic [15:0]    fifo_din;
  logic [16:0]    drop_sum;

  assign drop_cnt = drop_q;
  assign overrun  = overrun_q;

  always_comb begin
    mode_d    = mode_q;
    ts_d      = ts_q;
    marker_d  = 1'b0;
    pend_d    = pend_q;
    ts_lat_d  = ts_lat_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    ser_d     = ser_q;
    ser_idx_d = ser_idx_q;
    overrun_d = overrun_q;
    lost      = '0;
    grant_vld = 1'b0;
    grant_evt = 1'b0;
    grant_idx = '0;
    ser_adv   = 1'b0;
    fifo_wr   = 1'b0;
    fifo_din  = MARKER;

    if (!enable) mode_d = mode_e'(mode);
    is_evt   = (mode_q == MODE_EVENT);
    tick_act = enable && tick;
    ser_busy = (ser_q == S_EMIT);
    snap     = tick_act && !is_evt && !ser_busy;

    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(k);
      end
    end

    // Single write port: wrap marker, then lowest pending channel, then count serialiser.
    if (marker_q) begin
      fifo_wr  = 1'b1;
      fifo_din = MARKER;
    end else if (grant_vld) begin
      fifo_wr   = 1'b1;
      grant_evt = 1'b1;
      fifo_din  = pack_word(1'b1, grant_idx, ts_lat_q[grant_idx]);
    end else if (ser_busy) begin
      fifo_wr  = 1'b1;
      ser_adv  = 1'b1;
      fifo_din = pack_word(1'b0, ser_idx_q, shadow_q[ser_idx_q]);
    end

    if (grant_evt) pend_d[grant_idx] = 1'b0;

    // A channel whose word is being written this cycle can accept a fresh spike.
    if (enable && is_evt) begin
      for (int k = 0; k < NCH; k++) begin
        if (spike[k]) begin
          if (pend_d[k]) begin
            lost = lost + 1'b1;
          end else begin
            pend_d[k]   = 1'b1;
            ts_lat_d[k] = ts_q;
          end
        end
      end
    end

    if (tick_act && is_evt) begin
      ts_d = ts_q + 1'b1;
      if (ts_q == '1) marker_d = 1'b1;
    end

    if (tick_act && !is_evt && ser_busy) overrun_d = 1'b1;

    for (int k = 0; k < NCH; k++) begin
      if (snap) begin
        shadow_d[k] = cnt_q[k];
        cnt_d[k]    = '0;
      end
      if (enable && !is_evt && spike[k] && (cnt_d[k] != '1)) cnt_d[k] = cnt_d[k] + 1'b1;
    end

    if (snap) begin
      ser_d     = S_EMIT;
      ser_idx_d = '0;
    end else if (ser_adv) begin
      if (ser_idx_q == CW'(NCH - 1)) ser_d = S_IDLE;
      else                           ser_idx_d = ser_idx_q + 1'b1;
    end

    drop_sum = {1'b0, drop_q} + 17'(lost) + 17'(fifo_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      mode_q    <= MODE_EVENT;
      ts_q      <= '0;
      marker_q  <= 1'b0;
      pend_q    <= '0;
      ser_q     <= S_IDLE;
      ser_idx_q <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
      for (int k = 0; k < NCH; k++) begin
        ts_lat_q[k] <= '0;
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      ts_q      <= ts_d;
      marker_q  <= marker_d;
      pend_q    <= pend_d;
      ser_q     <= ser_d;
      ser_idx_q <= ser_idx_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
      ts_lat_q  <= ts_lat_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  spike_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (fifo_wr),
    .din     (fifo_din),
    .rd_en   (rd_en),
    .dout    (dout),
    .full    (fifo_full),
    .empty   (empty),
    .level   (level),
    .wr_drop (fifo_drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_spike_raster_fifo.sv
// Directed and randomized checks of the spike recorder against a word-level reference model.
module tb_spike_raster_fifo;

  localparam int NCH = 16;
  localparam int DL  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          clear = 1'b0;
  logic          tick = 1'b0;
  logic          rd_en = 1'b0;
  logic [NCH-1:0] spike = '0;
  logic [15:0]   dout;
  logic          empty;
  logic [DL:0]   level;
  logic [15:0]   drop_cnt;
  logic          overrun;

  int            tests = 0;
  int            fails = 0;
  logic [15:0]   exp_q[$];
  int            ts_m;

  always #5 clk = ~clk;

  spike_raster_fifo #(.NCH(NCH), .DEPTH_LOG2(DL), .TSW(11)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .mode     (mode),
    .clear    (clear),
    .tick     (tick),
    .spike    (spike),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .level    (level),
    .drop_cnt (drop_cnt),
    .overrun  (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [NCH-1:0] sp, input logic tk, input logic rd);
    spike = sp;
    tick  = tk;
    rd_en = rd;
    @(posedge clk);
    #1;
    spike = '0;
    tick  = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step('0, 1'b0, 1'b0);
    clear = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    enable = 1'b0;
    mode   = m;
    step('0, 1'b0, 1'b0);
    enable = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] expv);
    chk({tag, "_nonempty"}, {31'd0, empty}, 32'd0);
    chk(tag, {16'd0, dout}, {16'd0, expv});
    step('0, 1'b0, 1'b1);
  endtask

  task automatic drain_chk(input string tag);
    while (exp_q.size() > 0) pop_chk(tag, exp_q.pop_front());
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
  endtask

  function automatic logic [15:0] evt_word(input int ch, input int ts);
    logic [3:0]  c;
    logic [10:0] t;
    c = 4'(ch);
    t = 11'(ts % 2048);
    return {1'b1, c, t};
  endfunction

  function automatic logic [15:0] cnt_word(input int ch, input int n);
    logic [3:0]  c;
    logic [10:0] v;
    c = 4'(ch);
    v = (n > 2047) ? 11'd2047 : 11'(n);
    return {1'b0, c, v};
  endfunction

  initial begin
    int          n_cnt [NCH];
    logic [NCH-1:0] mask, m2;
    logic        tk;
    int          k;

    // Reset state
    idle(2);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    ts_m    = 0;

    // Event single spike after 5 ticks, one-edge latency
    for (int i = 0; i < 5; i++) step('0, 1'b1, 1'b0);
    ts_m = 5;
    step(16'h0008, 1'b0, 1'b0);
    chk("evt_lat_still_empty", {31'd0, empty}, 32'd1);
    step('0, 1'b0, 1'b0);
    chk("evt_lat_empty", {31'd0, empty}, 32'd0);
    chk("evt_lat_level", {27'd0, level}, 32'd1);
    pop_chk("evt_single", 16'h9805);

    // Simultaneous spikes at ts=7
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    ts_m = 7;
    step(16'h0011, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("sim_level1", {27'd0, level}, 32'd1);
    chk("sim_head", {16'd0, dout}, 32'h8007);
    step('0, 1'b0, 1'b0);
    chk("sim_level2", {27'd0, level}, 32'd2);
    pop_chk("sim_w0", 16'h8007);
    pop_chk("sim_w1", 16'hA007);
    chk("sim_drop", {16'd0, drop_cnt}, 32'd0);

    // Spike in tick cycle latches pre-increment ts; respike on a still-pending channel is lost
    step(16'h0006, 1'b1, 1'b0);
    ts_m = 8;
    step(16'h0004, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("lost_drop", {16'd0, drop_cnt}, 32'd1);
    pop_chk("tickspk_w0", 16'h8807);
    pop_chk("tickspk_w1", 16'h9007);

    // Randomized event bursts against the word-level model
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        step('0, 1'b1, 1'b0);
        ts_m++;
      end
      mask = NCH'($urandom_range(1, 16'hFFFF));
      tk   = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++) if (mask[c]) exp_q.push_back(evt_word(c, ts_m));
      step(mask, tk, 1'b0);
      if (tk) ts_m++;
      idle(17);
      chk("rnd_evt_level", {27'd0, level}, 32'($countones(mask)));
      drain_chk("rnd_evt_word");
    end
    chk("rnd_evt_drop", {16'd0, drop_cnt}, 32'd1);

    // Timestamp wrap produces exactly one marker and ts returns to 0
    do_clear();
    chk("clr_drop", {16'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 2048; i++) step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    idle(2);
    chk("wrap_level", {27'd0, level}, 32'd1);
    pop_chk("wrap_marker", 16'h0000);
    step(16'h0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    pop_chk("wrap_ts0", 16'h8000);

    // Count bins with saturation on ch0
    set_mode(1'b1);
    for (int i = 0; i < 2052; i++) step((i < 3) ? 16'h0005 : 16'h0001, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    idle(16);
    chk("cnt_level", {27'd0, level}, 32'd16);
    chk("cnt_drop", {16'd0, drop_cnt}, 32'd0);
    chk("cnt_overrun", {31'd0, overrun}, 32'd0);
    for (int c = 0; c < NCH; c++) exp_q.push_back(cnt_word(c, (c == 0) ? 2052 : (c == 2) ? 3 : 0));
    drain_chk("cnt_word");

    // Randomized bins; spikes in the tick cycle belong to the following bin
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++) n_cnt[c] = $urandom_range(0, 6);
      for (int cy = 0; cy < 6; cy++) begin
        mask = '0;
        for (int c = 0; c < NCH; c++) if (n_cnt[c] > cy) mask[c] = 1'b1;
        step(mask, 1'b0, 1'b0);
      end
      m2 = NCH'($urandom_range(0, 16'hFFFF));
      step(m2, 1'b1, 1'b0);
      idle(17);
      for (int c = 0; c < NCH; c++) exp_q.push_back(cnt_word(c, n_cnt[c]));
      drain_chk("rnd_cnt_bin");
      step('0, 1'b1, 1'b0);
      idle(17);
      for (int c = 0; c < NCH; c++) exp_q.push_back(cnt_word(c, m2[c] ? 1 : 0));
      drain_chk("rnd_cnt_next");
    end
    chk("rnd_cnt_overrun", {31'd0, overrun}, 32'd0);

    // FIFO overflow, write accepted at full when popping, then clear
    do_clear();
    for (int i = 0; i < 20; i++) step(NCH'(1) << (i % NCH), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_drop", {16'd0, drop_cnt}, 32'd4);
    chk("ovf_head", {16'd0, dout}, 32'h8000);
    step(16'h0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    chk("full_rw_level", {27'd0, level}, 32'd16);
    chk("full_rw_drop", {16'd0, drop_cnt}, 32'd4);
    chk("full_rw_head", {16'd0, dout}, 32'h8800);
    do_clear();
    chk("ovf_clr_level", {27'd0, level}, 32'd0);
    chk("ovf_clr_drop", {16'd0, drop_cnt}, 32'd0);
    chk("ovf_clr_empty", {31'd0, empty}, 32'd1);
    step('0, 1'b0, 1'b1);
    chk("rd_empty_level", {27'd0, level}, 32'd0);

    // Count overrun, then reset mid-serialisation aborts the bin
    set_mode(1'b1);
    step('0, 1'b1, 1'b0);
    idle(3);
    step('0, 1'b1, 1'b0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    reset_n = 1'b0;
    step('0, 1'b0, 1'b0);
    chk("ovr_rst_empty", {31'd0, empty}, 32'd1);
    chk("ovr_rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    idle(20);
    chk("ovr_rst_abort", {27'd0, level}, 32'd0);

    // enable=0 ignores spikes and ticks
    enable = 1'b0;
    mode   = 1'b0;
    step(16'hFFFF, 1'b1, 1'b0);
    idle(3);
    chk("dis_empty", {31'd0, empty}, 32'd1);
    enable = 1'b1;
    step(16'h0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    pop_chk("dis_ts_hold", 16'h8000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
